// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : FETCH while bytes are being issued/collected,
//                   HOLD while a complete instruction waits for decode.
//   INSTR_W       : instruction word width for the default configuration
//                   (4 bytes of 8 bits).
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_INSTR_BYTES = 4;
    localparam int INSTR_W         = DEF_INSTR_BYTES * DEF_DATA_W;

endpackage

// File: rtl/fetch_assembler.sv
// fetch_assembler
// Shift-in register that packs INSTR_BYTES ROM bytes into one word, first
// byte ending up in the MSBs.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : drop any partially assembled word
//   capture     : din holds a valid byte this cycle
//   din         : ROM byte
//   word_next   : word including the byte being captured now
//   done        : this capture completes the word (word_next is final)
module fetch_assembler
    import fetch_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int INSTR_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          capture,
    input  logic [DATA_W-1:0]             din,
    output logic [INSTR_BYTES*DATA_W-1:0] word_next,
    output logic                          done
);

    localparam int WORD_W = INSTR_BYTES * DATA_W;
    localparam int CNT_W  = $clog2(INSTR_BYTES + 1);

    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  byte_idx;

    // Shift form keeps INSTR_BYTES=1 legal (no zero-width slice).
    assign word_next = (shreg << DATA_W) | WORD_W'(din);
    assign done      = capture && (byte_idx == CNT_W'(INSTR_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (capture) begin
            if (done) begin
                shreg    <= '0;
                byte_idx <= '0;
            end else begin
                shreg    <= word_next;
                byte_idx <= byte_idx + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch unit: reads INSTR_BYTES consecutive bytes from a
// byte-wide ROM (one-cycle read latency), assembles them into ir and offers
// ir/pc to decode with a valid/ready handshake. Branch redirects flush any
// in-flight fetch and restart at redirect_addr.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   en             : global enable (stalls issues and FSM transitions)
//   redirect       : branch taken, with target redirect_addr
//   rom_en         : ROM read request, address rom_addr
//   rom_data       : ROM byte, valid the cycle after the request
//   ir, pc         : assembled instruction (first byte in MSBs), its address
//   ir_valid       : ir/pc hold a complete instruction
//   ir_ready       : decode accepts ir this cycle
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          redirect,
    input  logic [ADDR_W-1:0]             redirect_addr,
    output logic                          rom_en,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [DATA_W-1:0]             rom_data,
    output logic [INSTR_BYTES*DATA_W-1:0] ir,
    output logic                          ir_valid,
    input  logic                          ir_ready,
    output logic [ADDR_W-1:0]             pc
);

    localparam int WORD_W = INSTR_BYTES * DATA_W;
    localparam int CNT_W  = $clog2(INSTR_BYTES + 1);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CNT_W-1:0]  issue_idx;
    logic              pending;
    logic              flush;
    logic              handshake;
    logic              capture;
    logic              asm_done;
    logic [WORD_W-1:0] asm_word;

    // A taken redirect beats both the handshake and any byte capture.
    assign flush     = redirect && en;
    assign handshake = (state == HOLD) && ir_valid && ir_ready && en && !flush;
    assign capture   = pending && !flush;

    // rst_n gates rom_en so no request leaks out while reset is held.
    assign rom_en   = rst_n && (state == FETCH) && en && !redirect &&
                      (issue_idx < CNT_W'(INSTR_BYTES));
    assign rom_addr = fetch_addr + ADDR_W'(issue_idx);

    fetch_assembler #(
        .DATA_W      (DATA_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush || handshake),
        .capture   (capture),
        .din       (rom_data),
        .word_next (asm_word),
        .done      (asm_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Completion of the last byte moves to HOLD even with en low, since the
    // returning byte cannot be stalled.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = FETCH;
        end else begin
            case (state)
                FETCH:   if (asm_done)  state_next = HOLD;
                HOLD:    if (handshake) state_next = FETCH;
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_addr <= RESET_VEC;
            pc         <= RESET_VEC;
            issue_idx  <= '0;
            pending    <= 1'b0;
            ir         <= '0;
            ir_valid   <= 1'b0;
        end else if (flush) begin
            fetch_addr <= redirect_addr;
            issue_idx  <= '0;
            pending    <= 1'b0;
            ir_valid   <= 1'b0;
        end else begin
            pending <= rom_en;
            if (rom_en) begin
                issue_idx <= issue_idx + CNT_W'(1);
            end
            if (asm_done) begin
                ir       <= asm_word;
                pc       <= fetch_addr;
                ir_valid <= 1'b1;
            end
            if (handshake) begin
                ir_valid   <= 1'b0;
                fetch_addr <= pc + ADDR_W'(INSTR_BYTES);
                issue_idx  <= '0;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction fetch unit. It drives the byte-wide program ROM and assembles INSTR_BYTES consecutive bytes into one instruction word. It presents the word with a valid/ready handshake to decode and accepts branch redirects that flush in-flight fetches. It replaces the single-step pc/ir register pair between program ROM and decode.

Parameters:
ADDR_W, 16, width of program address / PC
DATA_W, 8, ROM read width (bits per byte lane)
INSTR_BYTES, 4, bytes per instruction (>=1); instruction word is INSTR_BYTES*DATA_W bits
RESET_VEC, 0, PC and fetch address after reset

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
en  input  1  global enable; 0 blocks new ROM issues and FSM transitions
redirect  input  1  branch taken; flush and refetch from redirect_addr
redirect_addr  input  ADDR_W  branch target
rom_en  output  1  ROM read request this cycle
rom_addr  output  ADDR_W  ROM byte address
rom_data  input  DATA_W  ROM read data, valid the cycle after the request
ir  output  INSTR_BYTES*DATA_W  assembled instruction, first-fetched byte in MSBs (op at top)
ir_valid  output  1  ir/pc hold a complete instruction
ir_ready  input  1  decode accepts ir this cycle
pc  output  ADDR_W  address of the instruction in ir

Behaviour:
- Reset (rst_n=0 at posedge; overrides everything): fetch_addr=pc=RESET_VEC, byte_idx=0, ir=0, ir_valid=0, pending=0, state=FETCH. rom_en=0 during reset.
- FSM states: FETCH (issuing/collecting bytes), HOLD (ir_valid=1, waiting for handshake).
- rom_en = (state==FETCH) & en & issue_idx<INSTR_BYTES & !redirect. rom_addr = fetch_addr + issue_idx, combinational, mod 2^ADDR_W.
- One byte issued per enabled FETCH cycle; issue_idx increments on each issue.
- pending: registered copy of rom_en. When pending=1, rom_data is shifted into the assembly register and byte_idx increments, regardless of en.
- When byte_idx reaches INSTR_BYTES-1 and that byte is captured: ir<=assembled word, pc<=fetch_addr, ir_valid<=1, state<=HOLD.
- Latency: first issue in cycle t gives ir_valid=1 in cycle t+INSTR_BYTES+1.
- HOLD: ir and pc stable while ir_valid & !ir_ready. ir_valid & ir_ready & en completes the handshake: ir_valid<=0, fetch_addr<=pc+INSTR_BYTES (wraps), counters cleared, state<=FETCH.
- en=0 in HOLD: the handshake is not taken even if ir_ready=1.
- redirect=1 & en=1 (priority over the handshake and capture):
  - next cycle: ir_valid=0, fetch_addr=redirect_addr, counters and pending cleared, state=FETCH;
  - a byte returning in the cycle after redirect is discarded;
  - a coincident ir_ready is treated as consumed;
  - no rom_en in the redirect cycle.
- redirect with en=0 is ignored.
- Wrap-around: an instruction straddling 2^ADDR_W-1 continues at address 0. pc holds the start address.
- Back-to-back redirects: the last one wins, with no stale ir_valid.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {FETCH, HOLD}; localparam INSTR_W = INSTR_BYTES*DATA_W.
- Sub-module fetch_assembler (parameters DATA_W, INSTR_BYTES): shift-in register with capture strobe, clear and done flag.
- Top level: FSM, address counters, redirect logic.

Test Plan:
- Reset release, ROM[0..3]=11,22,33,44, ir_ready=1: rom_addr 0,1,2,3 on cycles 1-4; ir=32'h11223344, pc=0, ir_valid=1 on cycle 6; next rom_addr=4.
- Backpressure: ir_ready=0 for 10 cycles while ir_valid: ir/pc constant, rom_en=0 throughout. Raising ir_ready causes fetch of addr 4 on the next cycle.
- Redirect to 16'h0100 after 2 of 4 bytes issued: the returning byte is discarded; next rom_addr=0100; ir assembled from ROM[0100..0103]; pc=0100; no ir_valid for the aborted instruction.
- Wrap: redirect to 16'hFFFE: rom_addr FFFE,FFFF,0000,0001; pc=FFFE; next fetch starts at 0002.
- en low for 3 cycles mid-assembly: no new issues; the pending byte is still captured; assembly resumes, and ir matches the uninterrupted case 3 cycles late.
- rst_n low mid-HOLD with redirect=1 same cycle: next cycle ir_valid=0, ir=0, pc=RESET_VEC; fetch restarts at RESET_VEC.
